// File: rtl/game_sequencer_if.sv
// Front-end/datapath bundle of the game sequencer. Direction encoding:
// 0=NONE, 1=UP, 2=DOWN, 3=LEFT, 4=RIGHT.
interface game_sequencer_if;
  logic       start;
  logic [2:0] dir_local;
  logic [2:0] dir_remote;
  logic       dir_remote_valid;
  logic       collision;
  logic       step;
  logic [2:0] dir1;
  logic [2:0] dir2;
  logic [1:0] game_state;
  logic [7:0] countdown;
  logic       com_err;

  // Strobes (start, dir_remote_valid, step) are single-cycle qualifiers with no
  // back-pressure: a strobe high at a rising edge is consumed at that edge.
  modport master (
    output start, dir_local, dir_remote, dir_remote_valid, collision,
    input  step, dir1, dir2, game_state, countdown, com_err
  );

  modport slave (
    input  start, dir_local, dir_remote, dir_remote_valid, collision,
    output step, dir1, dir2, game_state, countdown, com_err
  );
endinterface

// File: rtl/game_sequencer.sv
// Game-step timebase and state machine: issues step strobes applying both
// snakes' headings once the remote direction has arrived.
module game_sequencer #(
  parameter int TICK_CYCLES     = 6500000,
  parameter int TIMEOUT_TICKS   = 4,
  parameter int COUNTDOWN_STEPS = 3
) (
  input logic         clk,
  input logic         rst,
  game_sequencer_if.slave bus
);
  localparam logic [2:0] D_NONE  = 3'd0;
  localparam logic [2:0] D_UP    = 3'd1;
  localparam logic [2:0] D_DOWN  = 3'd2;
  localparam logic [2:0] D_LEFT  = 3'd3;
  localparam logic [2:0] D_RIGHT = 3'd4;

  localparam int TW = $clog2(TICK_CYCLES);
  localparam int MW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
  localparam logic [MW-1:0] MISS_LIMIT = MW'(TIMEOUT_TICKS);
  localparam logic [7:0]    CD_INIT    = 8'(COUNTDOWN_STEPS);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_RUN       = 2'd2,
    S_OVER      = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cd_q, cd_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [MW-1:0] miss_q, miss_d, miss_inc;
  logic [2:0]    pend1_q, pend1_d, pend2_q, pend2_d;
  logic [2:0]    dir1_q, dir1_d, dir2_q, dir2_d;
  logic          got2_q, got2_d;
  logic          step_q, step_d;
  logic          step_dly_q;
  logic          com_err_q, com_err_d;
  logic          tick;

  function automatic logic [2:0] opposite(input logic [2:0] d);
    case (d)
      D_UP:    opposite = D_DOWN;
      D_DOWN:  opposite = D_UP;
      D_LEFT:  opposite = D_RIGHT;
      D_RIGHT: opposite = D_LEFT;
      default: opposite = D_NONE;
    endcase
  endfunction

  assign tick     = ((state_q == S_COUNTDOWN) || (state_q == S_RUN)) && (tick_q == TICK_LAST);
  assign miss_inc = miss_q + MW'(1);

  always_comb begin
    state_d   = state_q;
    cd_d      = cd_q;
    tick_d    = '0;
    miss_d    = miss_q;
    pend1_d   = pend1_q;
    pend2_d   = pend2_q;
    dir1_d    = dir1_q;
    dir2_d    = dir2_q;
    got2_d    = got2_q;
    step_d    = 1'b0;
    com_err_d = com_err_q;

    if ((state_q == S_COUNTDOWN) || (state_q == S_RUN))
      tick_d = tick ? '0 : tick_q + TW'(1);

    case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          state_d   = S_COUNTDOWN;
          cd_d      = CD_INIT;
          tick_d    = '0;
          miss_d    = '0;
          got2_d    = 1'b0;
          pend1_d   = D_UP;
          pend2_d   = D_UP;
          dir1_d    = D_UP;
          dir2_d    = D_UP;
          com_err_d = 1'b0;
        end
      end
      S_COUNTDOWN: begin
        if (tick) begin
          if (cd_q == 8'd1) begin
            cd_d    = 8'd0;
            state_d = S_RUN;
          end else begin
            cd_d = cd_q - 8'd1;
          end
        end
      end
      S_RUN: begin
        // Reversal onto itself is never accepted as a new heading.
        if ((bus.dir_local != D_NONE) && (bus.dir_local != opposite(dir1_q)))
          pend1_d = bus.dir_local;
        if (bus.dir_remote_valid) begin
          pend2_d = bus.dir_remote;
          got2_d  = 1'b1;
        end
        if (tick) begin
          if (got2_q || bus.dir_remote_valid) begin
            step_d = 1'b1;
            dir1_d = pend1_q;
            dir2_d = bus.dir_remote_valid ? bus.dir_remote : pend2_q;
            got2_d = 1'b0;
            miss_d = '0;
          end else begin
            miss_d = miss_inc;
            if (miss_inc == MISS_LIMIT) begin
              com_err_d = 1'b1;
              state_d   = S_OVER;
            end
          end
        end else if (step_dly_q && bus.collision) begin
          state_d = S_OVER;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cd_q       <= 8'd0;
      tick_q     <= '0;
      miss_q     <= '0;
      pend1_q    <= D_UP;
      pend2_q    <= D_UP;
      dir1_q     <= D_UP;
      dir2_q     <= D_UP;
      got2_q     <= 1'b0;
      step_q     <= 1'b0;
      step_dly_q <= 1'b0;
      com_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cd_q       <= cd_d;
      tick_q     <= tick_d;
      miss_q     <= miss_d;
      pend1_q    <= pend1_d;
      pend2_q    <= pend2_d;
      dir1_q     <= dir1_d;
      dir2_q     <= dir2_d;
      got2_q     <= got2_d;
      step_q     <= step_d;
      step_dly_q <= step_q;
      com_err_q  <= com_err_d;
    end
  end

  assign bus.step       = step_q;
  assign bus.dir1       = dir1_q;
  assign bus.dir2       = dir2_q;
  assign bus.game_state = state_q;
  assign bus.countdown  = cd_q;
  assign bus.com_err    = com_err_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed vector bench for game_sequencer with TICK_CYCLES=8, TIMEOUT_TICKS=2,
// COUNTDOWN_STEPS=2.
module tb_game_sequencer;
  localparam logic [2:0] N = 3'd0, U = 3'd1, D = 3'd2, L = 3'd3, R = 3'd4;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_CD = 2'd1, ST_RUN = 2'd2, ST_OVER = 2'd3;

  typedef struct {
    logic       rst;
    logic       start;
    logic [2:0] dl;
    logic [2:0] dr;
    logic       drv;
    logic       col;
    int         n;
    logic [1:0] e_st;
    logic [7:0] e_cd;
    logic       e_step;
    logic [2:0] e_d1;
    logic [2:0] e_d2;
    logic       e_ce;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vq[$];

  game_sequencer_if bus ();

  game_sequencer #(
    .TICK_CYCLES(8), .TIMEOUT_TICKS(2), .COUNTDOWN_STEPS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s: got %0d expected %0d", idx, nm, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input logic [1:0] st, input logic [7:0] cd,
                               input logic stp, input logic [2:0] d1, input logic [2:0] d2,
                               input logic ce);
    chk("game_state", idx, 8'(bus.game_state), 8'(st));
    chk("countdown", idx, bus.countdown, cd);
    chk("step", idx, 8'(bus.step), 8'(stp));
    chk("dir1", idx, 8'(bus.dir1), 8'(d1));
    chk("dir2", idx, 8'(bus.dir2), 8'(d2));
    chk("com_err", idx, 8'(bus.com_err), 8'(ce));
  endtask

  task automatic add(input logic r, input logic s, input logic [2:0] dl, input logic [2:0] dr,
                     input logic drv, input logic col, input int n, input logic [1:0] st,
                     input logic [7:0] cd, input logic stp, input logic [2:0] d1,
                     input logic [2:0] d2, input logic ce);
    vec_t v;
    v.rst = r; v.start = s; v.dl = dl; v.dr = dr; v.drv = drv; v.col = col; v.n = n;
    v.e_st = st; v.e_cd = cd; v.e_step = stp; v.e_d1 = d1; v.e_d2 = d2; v.e_ce = ce;
    vq.push_back(v);
  endtask

  // Driver: strobes and rst apply to the first edge only, dir_local for all n edges.
  task automatic apply(input vec_t v);
    rst                  = v.rst;
    bus.start            = v.start;
    bus.dir_local        = v.dl;
    bus.dir_remote       = v.dr;
    bus.dir_remote_valid = v.drv;
    bus.collision        = v.col;
    for (int k = 0; k < v.n; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        rst                  = 1'b0;
        bus.start            = 1'b0;
        bus.dir_remote_valid = 1'b0;
        bus.collision        = 1'b0;
        bus.dir_remote       = N;
      end
    end
  endtask

  initial begin
    //   rst start dl dr drv col n    state    cd  stp d1 d2 ce
    // Countdown, start ignored in COUNTDOWN, remote strobe discarded in COUNTDOWN
    add(0, 1, N, N, 0, 0, 1,  ST_CD,   2, 0, U, U, 0);
    add(0, 1, N, N, 0, 0, 8,  ST_CD,   1, 0, U, U, 0);
    add(0, 0, N, R, 1, 0, 8,  ST_RUN,  0, 0, U, U, 0);
    // Local RIGHT, remote LEFT, one step one cycle after the tick; start ignored in RUN
    add(0, 0, R, N, 0, 0, 1,  ST_RUN,  0, 0, U, U, 0);
    add(0, 0, N, L, 1, 0, 1,  ST_RUN,  0, 0, U, U, 0);
    add(0, 1, N, N, 0, 0, 5,  ST_RUN,  0, 0, U, U, 0);
    add(0, 0, N, N, 0, 0, 1,  ST_RUN,  0, 1, R, L, 0);
    add(0, 0, N, N, 0, 0, 1,  ST_RUN,  0, 0, R, L, 0);
    // Two missed ticks -> com_err and OVER, outputs hold, restart clears
    add(0, 0, N, N, 0, 0, 7,  ST_RUN,  0, 0, R, L, 0);
    add(0, 0, N, N, 0, 0, 8,  ST_OVER, 0, 0, R, L, 1);
    add(0, 0, L, U, 1, 0, 3,  ST_OVER, 0, 0, R, L, 1);
    add(0, 1, N, N, 0, 0, 1,  ST_CD,   2, 0, U, U, 0);
    add(0, 0, N, N, 0, 0, 16, ST_RUN,  0, 0, U, U, 0);
    // Reverse and NONE ignored; remote strobe exactly in the tick cycle
    add(0, 0, D, N, 0, 0, 1,  ST_RUN,  0, 0, U, U, 0);
    add(0, 0, N, N, 0, 0, 6,  ST_RUN,  0, 0, U, U, 0);
    add(0, 0, N, R, 1, 0, 1,  ST_RUN,  0, 1, U, R, 0);
    // Collision during the step cycle is ignored, the cycle after ends the game
    add(0, 0, N, N, 0, 1, 1,  ST_RUN,  0, 0, U, R, 0);
    add(0, 0, N, N, 0, 1, 1,  ST_OVER, 0, 0, U, R, 0);
    // New game; strobe in COUNTDOWN must not allow the first RUN tick to step
    add(0, 1, N, N, 0, 0, 1,  ST_CD,   2, 0, U, U, 0);
    add(0, 0, N, D, 1, 0, 16, ST_RUN,  0, 0, U, U, 0);
    add(0, 0, L, N, 0, 0, 7,  ST_RUN,  0, 0, U, U, 0);
    add(0, 0, N, N, 0, 0, 1,  ST_RUN,  0, 0, U, U, 0);
    add(0, 0, N, L, 1, 0, 7,  ST_RUN,  0, 0, U, U, 0);
    // Reset in the tick cycle with a step pending
    add(1, 0, N, N, 0, 0, 1,  ST_IDLE, 0, 0, U, U, 0);
    add(0, 0, N, N, 0, 0, 1,  ST_IDLE, 0, 0, U, U, 0);

    bus.start = 1'b0; bus.dir_local = N; bus.dir_remote = N;
    bus.dir_remote_valid = 1'b0; bus.collision = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs(-1, ST_IDLE, 0, 0, U, U, 0);

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i]);
      check_outputs(i, vq[i].e_st, vq[i].e_cd, vq[i].e_step, vq[i].e_d1, vq[i].e_d2, vq[i].e_ce);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
